comparador_serial_der_izq: RTL and testbench
============================================

// Module: comparador_serial_der_izq
// PURPOSE
//  Bit-serial magnitude comparator controller. It sequences one right-to-left
//  comparison cell over two N-bit words, LSB first, one bit per clock.
//  Operands are captured on a start request. The carry-like state bit p is
//  iterated as P = (~Ai & Bi) | (p & (~Ai | Bi)).
//  The block produces a registered result plus an equality flag.
//  It sits between the operand source and any consumer that needs A<B or A<=B
//  without a parallel N-cell array.
// PARAMETERS
//  N   8   operand width in bits; N >= 2
//  CW  $clog2(N)   bit-counter width (derived, not overridable)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  inicio     in   1   start request; sampled only in REPOSO
//  modo       in   1   initial p: 0 -> result is A<B, 1 -> result is A<=B
//  A          in   N   operand A, captured with inicio
//  B          in   N   operand B, captured with inicio
//  ocupado    out  1   high while in CALCULA
//  listo      out  1   one-cycle pulse: resultado/igual valid and updated
//  resultado  out  1   final P of last completed comparison, held until next
//  igual      out  1   1 when the last completed comparison had A==B, held
// BEHAVIOUR
//  Reset (async, rst=1):
//   - state=REPOSO; regA, regB, p, cnt, eq = 0
//   - ocupado = listo = resultado = igual = 0
//   - Abort mid-operation is immediate: no listo is issued, result is lost.
//  FSM: REPOSO -> CALCULA -> FIN -> REPOSO.
//   - REPOSO: on an edge with inicio=1: regA<=A, regB<=B, p<=modo, eq<=1,
//     cnt<=0, go CALCULA. With inicio=0 the state holds.
//   - CALCULA: each edge:
//     - p <= P(p, regA[0], regB[0]); eq <= eq & ~(regA[0]^regB[0])
//     - regA, regB shift right by 1; cnt <= cnt+1
//     - On the edge with cnt==N-1 (N-th CALCULA edge): resultado <= P,
//       igual <= final eq, go FIN.
//   - FIN: lasts exactly one cycle; listo=1; go REPOSO unconditionally.
//  Outputs and latency:
//   - ocupado = (state==CALCULA); listo = (state==FIN). Both are decoded from
//     registered state, so no combinational path from inputs to outputs.
//   - Latency: listo rises N cycles after the edge that accepts inicio.
//     Throughput: one comparison per N+2 cycles (inicio must be re-sampled
//     in REPOSO).
//  Input handling:
//   - inicio is ignored in CALCULA and FIN. There is no queuing; the requester
//     must re-assert after listo.
//   - A, B, modo are used only at the accepting edge. Later changes do not
//     affect the running comparison.
//  Result register:
//   - resultado/igual change only on the transition into FIN. They are stable
//     from listo until the next completed comparison.
//  Equal operands:
//   - P reduces to p at every bit, so resultado==modo and igual==1.
//  Counter:
//   - cnt never exceeds N-1 and needs no wrap.
//   - For N a power of two, cnt is CW bits and the compare is against N-1.
// TESTING
//  1. N=8, A=8'h05, B=8'h09, modo=0, inicio 1 cycle
//     -> ocupado 8 cycles, listo 1 cycle, resultado=1, igual=0
//  2. A=B=8'hA5: modo=0 -> resultado=0, igual=1; repeat with modo=1
//     -> resultado=1, igual=1
//  3. A=8'h80, B=8'h7F, modo=1 -> resultado=0, igual=0
//     (MSB dominates all lower bits); swap operands -> resultado=1
//  4. Start A=8'h01, B=8'h02; hold inicio=1 and change A/B to 8'hFF/8'h00
//     during CALCULA -> resultado=1, exactly one listo, no second run
//     until inicio is seen in REPOSO
//  5. Assert rst on the 3rd CALCULA cycle
//     -> ocupado=0, listo=0, resultado=igual=0 immediately (async);
//     after release, a new start with A=8'h03, B=8'h03, modo=1
//     -> resultado=1, igual=1
//  6. Back-to-back: inicio held high continuously
//     -> listo pulses every N+2=10 cycles, each result matches its captured
//     operands

Source files
------------

// File: rtl/comparador_serial_der_izq_if.sv
// Request/result bundle for the bit-serial comparator: the master side issues
// operands and a start request, the slave side returns status and the result.
interface comparador_serial_der_izq_if #(
  parameter int N = 8
);
  logic         inicio;
  logic         modo;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         ocupado;
  logic         listo;
  logic         resultado;
  logic         igual;

  modport master (
    output inicio, modo, A, B,
    input  ocupado, listo, resultado, igual
  );

  modport slave (
    input  inicio, modo, A, B,
    output ocupado, listo, resultado, igual
  );
endinterface

// File: rtl/comparador_serial_der_izq.sv
// Bit-serial magnitude comparator: one right-to-left cell iterated LSB first,
// one bit per clock, yielding A<B (modo=0) or A<=B (modo=1) plus an equality flag.
//
// state   | meaning
// REPOSO  | idle, waiting for inicio; operands captured on the accepting edge
// CALCULA | shifting through N bit pairs, updating p and eq
// FIN     | one-cycle listo pulse, result registers just updated
module comparador_serial_der_izq #(
  parameter int N = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  comparador_serial_der_izq_if.slave  bus
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    CALCULA = 2'd1,
    FIN     = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  reg_a_q, reg_a_d;
  logic [N-1:0]  reg_b_q, reg_b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          p_q, p_d;
  logic          eq_q, eq_d;
  logic          ocupado_q, ocupado_d;
  logic          listo_q, listo_d;
  logic          resultado_q, resultado_d;
  logic          igual_q, igual_d;

  logic a0, b0, p_next, eq_next;

  always_comb begin
    a0      = reg_a_q[0];
    b0      = reg_b_q[0];
    p_next  = (~a0 & b0) | (p_q & (~a0 | b0));
    eq_next = eq_q & ~(a0 ^ b0);

    state_d     = state_q;
    reg_a_d     = reg_a_q;
    reg_b_d     = reg_b_q;
    cnt_d       = cnt_q;
    p_d         = p_q;
    eq_d        = eq_q;
    resultado_d = resultado_q;
    igual_d     = igual_q;

    case (state_q)
      REPOSO: begin
        if (bus.inicio) begin
          reg_a_d = bus.A;
          reg_b_d = bus.B;
          p_d     = bus.modo;
          eq_d    = 1'b1;
          cnt_d   = '0;
          state_d = CALCULA;
        end
      end
      CALCULA: begin
        p_d     = p_next;
        eq_d    = eq_next;
        reg_a_d = reg_a_q >> 1;
        reg_b_d = reg_b_q >> 1;
        // Terminal bit: publish the result and hold cnt at N-1.
        if (cnt_q == CW'(N - 1)) begin
          resultado_d = p_next;
          igual_d     = eq_next;
          state_d     = FIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FIN: begin
        state_d = REPOSO;
      end
      default: begin
        state_d = REPOSO;
      end
    endcase

    ocupado_d = (state_d == CALCULA);
    listo_d   = (state_d == FIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= REPOSO;
      reg_a_q     <= '0;
      reg_b_q     <= '0;
      cnt_q       <= '0;
      p_q         <= 1'b0;
      eq_q        <= 1'b0;
      ocupado_q   <= 1'b0;
      listo_q     <= 1'b0;
      resultado_q <= 1'b0;
      igual_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      reg_a_q     <= reg_a_d;
      reg_b_q     <= reg_b_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      eq_q        <= eq_d;
      ocupado_q   <= ocupado_d;
      listo_q     <= listo_d;
      resultado_q <= resultado_d;
      igual_q     <= igual_d;
    end
  end

  assign bus.ocupado   = ocupado_q;
  assign bus.listo     = listo_q;
  assign bus.resultado = resultado_q;
  assign bus.igual     = igual_q;
endmodule

// File: tb/tb_comparador_serial_der_izq.sv
// Directed bench for the bit-serial comparator: vector table plus hand-written
// sequences for held inicio, mid-run reset and back-to-back operation.
module tb_comparador_serial_der_izq;
  localparam int N = 8;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  comparador_serial_der_izq_if #(.N(N)) bus ();

  comparador_serial_der_izq #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       modo;
    logic       exp_res;
    logic       exp_eq;
  } vec_t;

  vec_t vecs [10];
  vec_t b2b  [3];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One full comparison starting from REPOSO; returns on the REPOSO cycle after listo.
  task automatic run_cmp(input logic [7:0] a, input logic [7:0] b, input logic m,
                         input logic er, input logic ee, input string nm);
    int n;
    @(negedge clk);
    bus.A = a; bus.B = b; bus.modo = m; bus.inicio = 1'b1;
    @(negedge clk);
    bus.inicio = 1'b0;
    n = 0;
    while (!bus.listo && n < 40) begin
      if (bus.ocupado) n++;
      @(negedge clk);
    end
    chk({nm, " busy_cycles"}, n, N);
    chk({nm, " listo"}, int'(bus.listo), 1);
    chk({nm, " resultado"}, int'(bus.resultado), int'(er));
    chk({nm, " igual"}, int'(bus.igual), int'(ee));
    @(negedge clk);
    chk({nm, " listo_width"}, int'(bus.listo), 0);
    chk({nm, " resultado_held"}, int'(bus.resultado), int'(er));
  endtask

  initial begin
    int n_listo;
    int k;
    int last;
    total = 0;
    bad   = 0;

    vecs[0] = '{8'h05, 8'h09, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'hA5, 8'hA5, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h7F, 8'h80, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{8'hFF, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{8'h3C, 8'h3D, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{8'h3D, 8'h3C, 1'b1, 1'b0, 1'b0};

    b2b[0] = '{8'h10, 8'h20, 1'b0, 1'b1, 1'b0};
    b2b[1] = '{8'h20, 8'h10, 1'b0, 1'b0, 1'b0};
    b2b[2] = '{8'h44, 8'h44, 1'b1, 1'b1, 1'b1};

    rst = 1'b1;
    bus.inicio = 1'b0; bus.modo = 1'b0; bus.A = '0; bus.B = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset ocupado", int'(bus.ocupado), 0);
    chk("reset listo", int'(bus.listo), 0);
    chk("reset resultado", int'(bus.resultado), 0);
    chk("reset igual", int'(bus.igual), 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run_cmp(vecs[i].a, vecs[i].b, vecs[i].modo, vecs[i].exp_res, vecs[i].exp_eq,
              $sformatf("vec%0d", i));

    // inicio held and operands scrambled during CALCULA
    @(negedge clk);
    bus.A = 8'h01; bus.B = 8'h02; bus.modo = 1'b0; bus.inicio = 1'b1;
    @(negedge clk);
    n_listo = 0;
    k = 0;
    while (!bus.listo && k < 40) begin
      bus.A = 8'hFF; bus.B = 8'h00;
      k++;
      @(negedge clk);
    end
    bus.inicio = 1'b0;
    chk("held listo", int'(bus.listo), 1);
    chk("held resultado", int'(bus.resultado), 1);
    chk("held igual", int'(bus.igual), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.listo || bus.ocupado) n_listo++;
    end
    chk("held no_rerun", n_listo, 0);

    // async reset in the 3rd CALCULA cycle, after a result of 1/1 is held
    run_cmp(8'hAA, 8'hAA, 1'b1, 1'b1, 1'b1, "pre_rst");
    @(negedge clk);
    bus.A = 8'h05; bus.B = 8'h09; bus.modo = 1'b0; bus.inicio = 1'b1;
    @(negedge clk);
    bus.inicio = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort ocupado", int'(bus.ocupado), 0);
    chk("abort listo", int'(bus.listo), 0);
    chk("abort resultado", int'(bus.resultado), 0);
    chk("abort igual", int'(bus.igual), 0);
    @(negedge clk);
    rst = 1'b0;
    run_cmp(8'h03, 8'h03, 1'b1, 1'b1, 1'b1, "post_rst");

    // back-to-back with inicio held high continuously
    @(negedge clk);
    bus.A = b2b[0].a; bus.B = b2b[0].b; bus.modo = b2b[0].modo; bus.inicio = 1'b1;
    k = 0;
    last = 0;
    for (int c = 0; c < 60 && k < 3; c++) begin
      @(negedge clk);
      if (bus.listo) begin
        chk($sformatf("b2b%0d resultado", k), int'(bus.resultado), int'(b2b[k].exp_res));
        chk($sformatf("b2b%0d igual", k), int'(bus.igual), int'(b2b[k].exp_eq));
        if (k > 0) chk($sformatf("b2b%0d period", k), c - last, N + 2);
        last = c;
        k++;
        if (k < 3) begin
          bus.A = b2b[k].a; bus.B = b2b[k].b; bus.modo = b2b[k].modo;
        end
      end
    end
    bus.inicio = 1'b0;
    chk("b2b completions", k, 3);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
